// File: rtl/uart_avalon_master.sv
// UART-to-Avalon-MM bridge: 8N1 command frames ('W'/'R' + address [+ data]) drive single
// Avalon master transfers; writes answer 'K', reads answer the captured data MSB first.
module uart_avalon_master #(
  parameter int N_BIT = 16,
  parameter int N_LOG = $clog2(N_BIT),
  parameter int AAW   = 8,
  parameter int ADW   = 32,
  parameter int ABW   = ADW/8,
  parameter int NAB   = (AAW+7)/8,
  parameter int NDB   = ADW/8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rxd,
  output logic           uart_txd,
  output logic [AAW-1:0] avalon_address,
  output logic           avalon_read,
  output logic           avalon_write,
  output logic [ADW-1:0] avalon_writedata,
  output logic [ABW-1:0] avalon_byteenable,
  input  logic [ADW-1:0] avalon_readdata,
  input  logic           avalon_waitrequest
);
  localparam int AS = NAB*8;
  localparam logic [N_LOG-1:0] BIT_LAST = N_LOG'(N_BIT-1);
  // loaded on edge detection so the start sample lands (N_BIT-1)/2 cycles later
  localparam logic [N_LOG-1:0] HALF     = N_LOG'((N_BIT-1)/2 - 1);

  typedef enum logic [2:0] {IDLE, ADR, DAT, BUS, RSP} state_t;

  // receiver
  logic             rx_s1, rx_s2, rx_prev, rx_busy, rx_valid;
  logic [N_LOG-1:0] rx_cnt;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_sh;

  assign rx_valid = rx_busy && (rx_cnt == '0) && (rx_bit == 4'd9) && rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_busy <= 1'b0; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
    end else begin
      rx_s1 <= uart_rxd; rx_s2 <= rx_s1; rx_prev <= rx_s2;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1; rx_cnt <= HALF; rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - N_LOG'(1);
      end else begin
        rx_cnt <= BIT_LAST;
        rx_bit <= rx_bit + 4'd1;
        if ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9) rx_busy <= 1'b0;
        else if (rx_bit != 4'd0) rx_sh <= {rx_s2, rx_sh[7:1]};
      end
    end
  end

  // transmitter: the shift register idles at all ones and drives the line directly
  logic             tx_busy, tx_load, tx_done;
  logic [N_LOG-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [9:0]       tx_sh;
  logic [7:0]       tx_byte;

  assign uart_txd = tx_sh[0];
  assign tx_done  = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
    end else if (tx_load) begin
      tx_busy <= 1'b1; tx_cnt <= BIT_LAST; tx_bit <= '0; tx_sh <= {1'b1, tx_byte, 1'b0};
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - N_LOG'(1);
      end else begin
        tx_cnt <= BIT_LAST;
        tx_bit <= tx_bit + 4'd1;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end
    end
  end

  // command FSM
  state_t        state, state_nxt;
  logic          op_wr;
  logic [2:0]    bcnt, nbytes;
  logic [AS-1:0] adr_sh;
  logic [ADW-1:0] rd_sh;

  assign avalon_address    = adr_sh[AAW-1:0];
  assign avalon_byteenable = '1;
  assign nbytes            = op_wr ? 3'd1 : 3'(NDB);

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_byte   = op_wr ? 8'h4B : rd_sh[ADW-1 -: 8];
    case (state)
      IDLE: if (rx_valid && (rx_sh == 8'h57 || rx_sh == 8'h52)) state_nxt = ADR;
      ADR:  if (rx_valid && bcnt == 3'(NAB-1)) state_nxt = op_wr ? DAT : BUS;
      DAT:  if (rx_valid && bcnt == 3'(NDB-1)) state_nxt = BUS;
      BUS:  if (!avalon_waitrequest) state_nxt = RSP;
      RSP: begin
        // bcnt counts bytes loaded; the next one goes out as the previous stop bit ends
        if (bcnt == 3'd0 && !tx_busy) tx_load = 1'b1;
        else if (tx_done) begin
          if (bcnt == nbytes) state_nxt = IDLE;
          else tx_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; op_wr <= 1'b0; bcnt <= '0; adr_sh <= '0; rd_sh <= '0;
      avalon_writedata <= '0; avalon_read <= 1'b0; avalon_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) bcnt <= '0;
      else if (tx_load || (rx_valid && (state == ADR || state == DAT))) bcnt <= bcnt + 3'd1;
      if (state == IDLE && rx_valid) op_wr <= (rx_sh == 8'h57);
      if (state == ADR && rx_valid) adr_sh <= AS'({adr_sh, rx_sh});
      if (state == DAT && rx_valid) avalon_writedata <= ADW'({avalon_writedata, rx_sh});
      if (state != BUS && state_nxt == BUS) begin
        avalon_write <= op_wr;
        avalon_read  <= ~op_wr;
      end else if (state == BUS && !avalon_waitrequest) begin
        avalon_write <= 1'b0;
        avalon_read  <= 1'b0;
        rd_sh        <= avalon_readdata;
      end else if (tx_load) begin
        rd_sh <= ADW'({rd_sh, 8'h00});
      end
    end
  end
endmodule

// File: tb/tb_uart_avalon_master.sv
// Bench for uart_avalon_master: UART command frames in, scoreboarded bus transfers
// and decoded response bytes out.
module tb_uart_avalon_master;
  localparam int N_BIT = 4, AAW = 8, ADW = 32, ABW = 4;

  logic           clk = 1'b0, rst = 1'b1, uart_rxd = 1'b1, uart_txd;
  logic           avalon_read, avalon_write, avalon_waitrequest = 1'b0;
  logic [AAW-1:0] avalon_address;
  logic [ADW-1:0] avalon_writedata, avalon_readdata = '0;
  logic [ABW-1:0] avalon_byteenable;

  uart_avalon_master #(.N_BIT(N_BIT), .AAW(AAW), .ADW(ADW)) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .avalon_address(avalon_address), .avalon_read(avalon_read), .avalon_write(avalon_write),
    .avalon_writedata(avalon_writedata), .avalon_byteenable(avalon_byteenable),
    .avalon_readdata(avalon_readdata), .avalon_waitrequest(avalon_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [AAW-1:0] adr; logic [ADW-1:0] dat; int waits; } bus_t;
  typedef struct { logic [7:0] b; logic first; } txe_t;
  bus_t exp_bus[$];
  txe_t exp_tx[$];

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // slave model: stalls for the scripted number of cycles, then completes
  int stb_cyc = 0, wl = 0, done_cyc = 0;
  logic done_chk = 1'b0;
  logic [AAW-1:0] adr0;
  logic [ADW-1:0] dat0;
  always @(negedge clk) begin
    if (done_chk) begin
      chk("strobe_drop", {avalon_read, avalon_write}, 0);
      done_chk = 1'b0;
    end
    if (rst) begin
      avalon_waitrequest = 1'b0; stb_cyc = 0;
    end else if (avalon_read || avalon_write) begin
      if (exp_bus.size() == 0) begin
        chk("bus_spurious", {avalon_read, avalon_write}, 0);
        avalon_waitrequest = 1'b0;
      end else begin
        if (stb_cyc == 0) begin
          wl = exp_bus[0].waits; adr0 = avalon_address; dat0 = avalon_writedata;
        end else begin
          chk("adr_stable", avalon_address, adr0);
          chk("wdat_stable", avalon_writedata, dat0);
        end
        stb_cyc++;
        if (wl > 0) begin
          wl--; avalon_waitrequest = 1'b1; avalon_readdata = $urandom;
        end else begin
          avalon_waitrequest = 1'b0;
          avalon_readdata = exp_bus[0].dat;
          chk("op", {avalon_write, avalon_read}, {exp_bus[0].wr, ~exp_bus[0].wr});
          chk("address", avalon_address, exp_bus[0].adr);
          if (exp_bus[0].wr) chk("writedata", avalon_writedata, exp_bus[0].dat);
          chk("byteenable", avalon_byteenable, 4'hF);
          chk("strobe_len", stb_cyc, exp_bus[0].waits + 1);
          void'(exp_bus.pop_front());
          stb_cyc = 0; done_chk = 1'b1; done_cyc = cyc;
        end
      end
    end else begin
      avalon_waitrequest = 1'b0; avalon_readdata = $urandom; stb_cyc = 0;
    end
  end

  // txd decoder: start detected at offset 0, bit k sampled at 4k+2 negedges later
  logic dec_busy = 1'b0, tx_prev = 1'b1;
  int dec_t = 0, start_cyc = 0, last_start = 0, tx_seen = 0;
  logic [7:0] dec_b = '0;
  txe_t te;
  always @(negedge clk) begin
    if (rst) begin
      dec_busy = 1'b0; tx_prev = 1'b1;
    end else begin
      if (!dec_busy) begin
        if (tx_prev && !uart_txd) begin dec_busy = 1'b1; dec_t = 0; start_cyc = cyc; end
      end else begin
        dec_t++;
        if (dec_t == 2) chk("tx_start", uart_txd, 0);
        else if (dec_t >= 6 && dec_t <= 34 && dec_t % 4 == 2) dec_b = {uart_txd, dec_b[7:1]};
        else if (dec_t == 4*9+2) begin
          dec_busy = 1'b0; tx_seen++;
          chk("tx_stop", uart_txd, 1);
          if (exp_tx.size() == 0) chk("tx_spurious", exp_tx.size(), 1);
          else begin
            te = exp_tx.pop_front();
            chk("tx_byte", dec_b, te.b);
            if (te.first) chk("tx_latency", 64'(start_cyc - done_cyc <= 2), 1);
            else chk("tx_gap", start_cyc - last_start, 10*N_BIT);
          end
          last_start = start_cyc;
        end
      end
      tx_prev = uart_txd;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (N_BIT) @(negedge clk);
    end
    uart_rxd = 1'b1;
    if (!stop_bit) repeat (2*N_BIT) @(negedge clk);
  endtask

  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = n-1; i >= 0; i--) send_byte(v[8*i +: 8], 1'b1);
  endtask

  task automatic expect_write(input logic [AAW-1:0] a, input logic [ADW-1:0] d, input int w);
    exp_bus.push_back('{1'b1, a, d, w});
    exp_tx.push_back('{8'h4B, 1'b1});
  endtask

  task automatic expect_read(input logic [AAW-1:0] a, input logic [ADW-1:0] d);
    exp_bus.push_back('{1'b0, a, d, 0});
    for (int i = 0; i < 4; i++) exp_tx.push_back('{d[31-8*i -: 8], i == 0});
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || dec_busy) && k < maxc) begin
      @(negedge clk); k++;
    end
    chk("drain", exp_bus.size() + exp_tx.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  int base, k;
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_read", avalon_read, 0);
    chk("rst_write", avalon_write, 0);
    chk("rst_address", avalon_address, 0);
    chk("rst_writedata", avalon_writedata, 0);
    chk("rst_byteenable", avalon_byteenable, 4'hF);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    expect_write(8'h10, 32'hDEADBEEF, 0);
    send_seq(64'h57_10_DE_AD_BE_EF, 6);
    drain(2000);

    expect_write(8'h10, 32'hDEADBEEF, 3);
    send_seq(64'h57_10_DE_AD_BE_EF, 6);
    drain(2000);

    expect_read(8'h20, 32'h12345678);
    send_seq(64'h52_20, 2);
    drain(2000);

    // noise and a framing-errored 'W' must not start a command
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h57, 1'b0);
    repeat (20) @(negedge clk);
    expect_read(8'h04, 32'hA1B2C3D4);
    send_seq(64'h52_04, 2);
    drain(2000);

    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    expect_write(8'h01, 32'h0000002A, 0);
    send_seq(64'h57_01_00_00_00_2A, 6);
    drain(2000);

    // reset in the middle of the third response byte
    base = tx_seen;
    expect_read(8'h30, 32'hCAFEF00D);
    send_seq(64'h52_30, 2);
    k = 0;
    while (tx_seen < base + 2 && k < 2000) begin @(negedge clk); k++; end
    chk("rsp_progress", tx_seen - base, 2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_tx.delete();
    @(negedge clk);
    chk("rst_mid_txd", uart_txd, 1);
    chk("rst_mid_strobe", {avalon_read, avalon_write}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_silent", tx_seen - base, 2);

    expect_read(8'h08, 32'h0BADBEEF);
    send_seq(64'h52_08, 2);
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
